// File: rtl/ula_seq.sv
// Multi-cycle sequential ALU with a start/busy/done handshake and registered outputs.
// A and B are latched when an operation is accepted; multiply is an iterative shift-add.
module ula_seq #(
    parameter int N = 8
) (
    input  logic             Tclk,
    input  logic             Tclr,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       selec,
    input  logic [N-1:0]     A_in,
    input  logic [N-1:0]     B_in,
    output logic             busy,
    output logic             done,
    output logic [N:0]       S,
    output logic [2*N-1:0]   Smulti,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [2:0]      op_reg;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  acc;

    logic [N:0]      exec_res;
    logic            exec_ovf;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;

    // Single-cycle result computed from the latched operands, written in EXEC.
    always_comb begin
        exec_res = '0;
        exec_ovf = 1'b0;
        case (op_reg)
            3'b000: begin
                exec_res = {1'b0, a_reg} + {1'b0, b_reg};
                exec_ovf = (a_reg[N-1] == b_reg[N-1]) && (exec_res[N-1] != a_reg[N-1]);
            end
            3'b001: begin
                exec_res = {1'b0, a_reg} - {1'b0, b_reg};
                exec_ovf = (a_reg[N-1] != b_reg[N-1]) && (exec_res[N-1] != a_reg[N-1]);
            end
            3'b010:  exec_res = {1'b0, a_reg & b_reg};
            3'b011:  exec_res = {1'b0, a_reg | b_reg};
            3'b100:  exec_res = {1'b0, a_reg ^ b_reg};
            3'b101:  exec_res = {1'b0, ~a_reg};
            3'b110:  exec_res = {a_reg, 1'b0};
            default: exec_res = '0;
        endcase
    end

    // Accumulator holds {partial product, remaining multiplier bits}; the carry of
    // the upper-half add becomes the new MSB as the whole thing shifts right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_reg} : '0);
        mul_next = {mul_sum, acc[N-1:1]};
    end

    always_ff @(posedge Tclk or posedge Tclr) begin
        if (Tclr) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            S      <= '0;
            Smulti <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= A_in;
                        b_reg  <= B_in;
                        op_reg <= selec;
                        busy   <= 1'b1;
                        if (selec == 3'b111) begin
                            acc   <= {{N{1'b0}}, B_in};
                            cnt   <= CW'(N);
                            state <= MUL;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    S     <= exec_res;
                    zero  <= (exec_res[N-1:0] == '0);
                    ovf   <= exec_ovf;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        Smulti <= mul_next;
                        zero   <= (mul_next == '0);
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (N=8): table vectors, hand-written handshake
// sequences and random operations against a stateful arithmetic reference model.
module tb_ula_seq;

    localparam int N = 8;

    logic           Tclk;
    logic           Tclr;
    logic           en;
    logic           start;
    logic [2:0]     selec;
    logic [N-1:0]   A_in;
    logic [N-1:0]   B_in;
    logic           busy;
    logic           done;
    logic [N:0]     S;
    logic [2*N-1:0] Smulti;
    logic           zero;
    logic           ovf;

    ula_seq #(.N(N)) dut (
        .Tclk   (Tclk),
        .Tclr   (Tclr),
        .en     (en),
        .start  (start),
        .selec  (selec),
        .A_in   (A_in),
        .B_in   (B_in),
        .busy   (busy),
        .done   (done),
        .S      (S),
        .Smulti (Smulti),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial begin
        Tclk = 1'b0;
        forever #5 Tclk = ~Tclk;
    end

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [8:0]  s;
        logic [15:0] sm;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[15];

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: what the outputs should hold after the last completed op.
    int mS  = 0;
    int mSm = 0;
    int mZ  = 0;
    int mO  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the unsigned/signed operand values.
    task automatic modelOp(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        mO = 0;
        case (sel)
            3'd0: begin mS = ua + ub; r = sa + sb; mO = (r > 127 || r < -128) ? 1 : 0; end
            3'd1: begin
                mS = ((ua - ub + 256) % 256) + ((ua < ub) ? 256 : 0);
                r  = sa - sb;
                mO = (r > 127 || r < -128) ? 1 : 0;
            end
            3'd2: mS = ua & ub;
            3'd3: mS = ua | ub;
            3'd4: mS = ua ^ ub;
            3'd5: mS = 255 - ua;
            3'd6: mS = ua * 2;
            default: mSm = ua * ub;
        endcase
        if (sel == 3'd7) mZ = (mSm == 0) ? 1 : 0;
        else             mZ = ((mS % 256) == 0) ? 1 : 0;
    endtask

    task automatic waitDone(inout int lat);
        do begin
            @(negedge Tclk);
            lat++;
        end while (!done && lat < 40);
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    // Issues one op and returns at the negedge where done is seen.
    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                                 output int lat);
        @(negedge Tclk);
        selec = sel;
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        @(negedge Tclk);
        start = 1'b0;
        selec = $urandom_range(0, 7);
        A_in  = $urandom;
        B_in  = $urandom;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        waitDone(lat);
    endtask

    task automatic checkModel(input string tag, input logic [2:0] sel, input int lat);
        checkOutput({tag, "_S"}, 32'(S), 32'(mS));
        checkOutput({tag, "_Smulti"}, 32'(Smulti), 32'(mSm));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(mZ));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(mO));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_latency"}, 32'(lat), (sel == 3'd7) ? 32'd8 : 32'd1);
    endtask

    initial begin
        int  lat;
        bit  sawDone;
        logic [2:0] rs;
        logic [7:0] ra, rb;

        vecs[0]  = '{3'd0, 8'd200, 8'd3,   9'd203,  16'd0,     1'b0, 1'b0};
        vecs[1]  = '{3'd1, 8'd50,  8'd100, 9'h1CE,  16'd0,     1'b0, 1'b0};
        vecs[2]  = '{3'd1, 8'd100, 8'd100, 9'd0,    16'd0,     1'b1, 1'b0};
        vecs[3]  = '{3'd0, 8'd100, 8'd100, 9'd200,  16'd0,     1'b0, 1'b1};
        vecs[4]  = '{3'd1, 8'h80,  8'h01,  9'h07F,  16'd0,     1'b0, 1'b1};
        vecs[5]  = '{3'd7, 8'd55,  8'd100, 9'h07F,  16'd5500,  1'b0, 1'b0};
        vecs[6]  = '{3'd7, 8'd255, 8'd255, 9'h07F,  16'd65025, 1'b0, 1'b0};
        vecs[7]  = '{3'd7, 8'd0,   8'd77,  9'h07F,  16'd0,     1'b1, 1'b0};
        vecs[8]  = '{3'd2, 8'hF0,  8'h3C,  9'h030,  16'd0,     1'b0, 1'b0};
        vecs[9]  = '{3'd3, 8'hF0,  8'h0F,  9'h0FF,  16'd0,     1'b0, 1'b0};
        vecs[10] = '{3'd4, 8'hAA,  8'hAA,  9'h000,  16'd0,     1'b1, 1'b0};
        vecs[11] = '{3'd5, 8'h0F,  8'h00,  9'h0F0,  16'd0,     1'b0, 1'b0};
        vecs[12] = '{3'd6, 8'h81,  8'h00,  9'h102,  16'd0,     1'b0, 1'b0};
        vecs[13] = '{3'd0, 8'd128, 8'd128, 9'h100,  16'd0,     1'b1, 1'b1};
        vecs[14] = '{3'd7, 8'd3,   8'd5,   9'h100,  16'd15,    1'b0, 1'b0};

        Tclr  = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        selec = '0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(negedge Tclk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_S", 32'(S), 32'd0);
        checkOutput("reset_Smulti", 32'(Smulti), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        Tclr = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, lat);
            modelOp(vecs[i].sel, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_S", i), 32'(S), 32'(vecs[i].s));
            checkOutput($sformatf("vec%0d_Smulti", i), 32'(Smulti), 32'(vecs[i].sm));
            checkOutput($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),
                        (vecs[i].sel == 3'd7) ? 32'd8 : 32'd1);
            @(negedge Tclk);
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start during a busy multiply must be ignored
        @(negedge Tclk);
        selec = 3'd7; A_in = 8'd12; B_in = 8'd13; start = 1'b1;
        @(negedge Tclk);
        selec = 3'd7; A_in = 8'd50; B_in = 8'd50;
        lat = 1;
        @(negedge Tclk);
        start = 1'b0;
        waitDone(lat);
        modelOp(3'd7, 8'd12, 8'd13);
        checkModel("busy_ignore", 3'd7, lat);
        @(negedge Tclk);
        checkOutput("busy_ignore_no_restart", 32'(busy), 32'd0);

        // back-to-back: new start in the done cycle
        applyStimulus(3'd0, 8'd10, 8'd20, lat);
        modelOp(3'd0, 8'd10, 8'd20);
        checkModel("b2b_first", 3'd0, lat);
        selec = 3'd1; A_in = 8'd7; B_in = 8'd9; start = 1'b1;
        @(negedge Tclk);
        start = 1'b0;
        checkOutput("b2b_accept_busy", 32'(busy), 32'd1);
        checkOutput("b2b_accept_done", 32'(done), 32'd0);
        lat = 0;
        waitDone(lat);
        modelOp(3'd1, 8'd7, 8'd9);
        checkModel("b2b_second", 3'd1, lat);

        // start while en=0 is not accepted
        @(negedge Tclk);
        en = 1'b0; selec = 3'd0; A_in = 8'd1; B_in = 8'd1; start = 1'b1;
        @(negedge Tclk);
        en = 1'b1; start = 1'b0;
        @(negedge Tclk);
        checkOutput("en0_start_ignored", 32'(busy), 32'd0);

        // en low for 3 cycles mid-multiply
        selec = 3'd7; A_in = 8'd9; B_in = 8'd7; start = 1'b1;
        @(negedge Tclk);
        start = 1'b0;
        lat = 0;
        repeat (2) begin @(negedge Tclk); lat++; end
        en = 1'b0;
        repeat (3) begin @(negedge Tclk); lat++; end
        checkOutput("stall_busy_held", 32'(busy), 32'd1);
        en = 1'b1;
        waitDone(lat);
        checkOutput("stall_latency", 32'(lat), 32'd11);
        checkOutput("stall_Smulti", 32'(Smulti), 32'd63);
        modelOp(3'd7, 8'd9, 8'd7);

        // reset in the middle of a multiply
        @(negedge Tclk);
        selec = 3'd7; A_in = 8'd200; B_in = 8'd200; start = 1'b1;
        @(negedge Tclk);
        start = 1'b0;
        repeat (3) @(negedge Tclk);
        Tclr = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_S", 32'(S), 32'd0);
        checkOutput("midrst_Smulti", 32'(Smulti), 32'd0);
        checkOutput("midrst_zero", 32'(zero), 32'd0);
        @(negedge Tclk);
        Tclr = 1'b0;
        mS = 0; mSm = 0; mZ = 0; mO = 0;
        sawDone = 1'b0;
        repeat (10) begin
            @(negedge Tclk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("midrst_no_done", 32'(sawDone), 32'd0);
        applyStimulus(3'd7, 8'd15, 8'd17, lat);
        modelOp(3'd7, 8'd15, 8'd17);
        checkModel("after_rst_mul", 3'd7, lat);

        // random operations against the model
        for (int i = 0; i < 40; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(rs, ra, rb, lat);
            modelOp(rs, ra, rb);
            checkModel($sformatf("rand%0d", i), rs, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, multi-cycle sequential ALU: successor to the combinational `ULA`, keeping its operand/result port naming. It adds a start/busy/done handshake, registered outputs, status flags, and an iterative shift-add multiplier that replaces the array multiplier. It sits between the operand registers and the result bus, accepts one operation at a time, and holds each result until the next one completes.

## Interface
- `N`, 8, operand width; legal range N >= 2.
- `Tclk`  in  1  clock; all state changes on rising edge.
- `Tclr`  in  1  reset; asynchronous, active-high; clears all state and outputs.
- `en`  in  1  clock enable; 0 freezes the FSM, counter and all registers.
- `start`  in  1  operation request; sampled only when `busy`=0 and `en`=1.
- `selec`  in  3  operation code; latched with `start`.
- `A_in`  in  N  operand A; latched with `start`.
- `B_in`  in  N  operand B; latched with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when a result is written.
- `S`  out  N+1  ALU result; bit N is carry/borrow/shift-out.
- `Smulti`  out  2N  product.
- `zero`  out  1  result equals zero.
- `ovf`  out  1  signed overflow (add/sub only).

## Operation
- Opcodes (unsigned operands unless noted):
  - 000: add, S = A+B.
  - 001: sub, S = {borrow, (A-B) mod 2^N}.
  - 010: AND, S = {0, A&B}.
  - 011: OR, S = {0, A|B}.
  - 100: XOR, S = {0, A^B}.
  - 101: NOT A, S = {0, ~A}.
  - 110: shift left A by 1, S = {A[N-1], A[N-2:0], 0}.
  - 111: multiply, Smulti = A*B.
- FSM states:
  - IDLE: `start` accepted → latch operands and opcode; go to EXEC if selec≠111, else to MUL with counter=N.
  - EXEC: write S and flags; pulse `done`; go to IDLE.
  - MUL: each enabled edge, if multiplier LSB=1 add multiplicand into the upper accumulator half; shift accumulator right one bit; decrement counter. When the counter reaches 0, write Smulti and flags, pulse `done`, go to IDLE.
- Non-multiply ops leave Smulti unchanged; multiply leaves S unchanged.
- Flags:
  - `zero`: set when S[N-1:0]==0 for EXEC ops, or when Smulti==0 for multiply.
  - `ovf`: add sets it when A[N-1]==B[N-1] and the sum's bit N-1 differs from them; sub sets it when A[N-1]≠B[N-1] and the result's bit N-1 differs from A[N-1]; cleared for all other ops.
  - Flags update only when `done` is written.
- `start` while `busy`=1 is ignored; operands and opcode are not relatched.
- Latched operands are used throughout; changes on A_in/B_in/selec during busy have no effect.

## Timing
- Reset values: busy=0, done=0, S=0, Smulti=0, zero=0, ovf=0; FSM=IDLE, counter=0.
- Acceptance: `start` accepted on edge k sets `busy`=1 after edge k.
- Non-multiply latency: after edge k+1, S/flags are valid, `done`=1 and `busy`=0 for exactly one cycle.
- Multiply latency: result/flags are valid after edge k+N, with `done`=1 and `busy`=0 at that point.
- Back-to-back: a new `start` is accepted in the `done` cycle, giving throughput of one op per 2 cycles (EXEC) or N+1 cycles (MUL).
- `en`=0: no state changes and `done` holds its value; each disabled cycle extends latency by one. A `start` with `en`=0 is not accepted.
- `Tclr` mid-operation: immediate clear to reset values; the pending result is lost and no `done` is issued.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then add, N=8: A=200, B=3, selec=000, start at edge k → after edge k+1, S=9'd203, done=1 for one cycle, zero=0, ovf=0, Smulti=0.
- Sub with borrow: A=50, B=100, selec=001 → S=9'h1CE; then A=100, B=100 → S=0, zero=1.
- Signed overflow: A=100, B=100, selec=000 → S=9'd200, ovf=1. Then A=8'h80, B=8'h01, selec=001 → ovf=1.
- Multiply: 55×100 → Smulti=16'd5500 exactly 8 edges after acceptance. 255×255 → 16'd65025. 0×77 → Smulti=0, zero=1.
- Handshake: assert `start` with 50×50 during a busy multiply → ignored, and the first product is unaffected. A new start issued in the `done` cycle is accepted. Hold en=0 for 3 cycles mid-multiply → done arrives 3 cycles late with the correct product.
- Asserting `Tclr` at cycle 4 of a multiply → all outputs go to 0 immediately and no done pulse occurs. The next multiply after release completes correctly.
